// File: rtl/instr_issue_queue.sv
// FIFO instruction buffer feeding the DataPath: one registered issue per cycle,
// NOP bubbles when empty, stall holds the current issue, flush drops everything.
module instr_issue_queue #(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 8,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(32'h0000_0013),
  parameter int             CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [XLEN-1:0]          wr_instr,
  output logic                     wr_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [XLEN-1:0]          instruction_word,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_s;
  logic             pop_s;
  logic             full_s;

  assign full_s           = (occ_q == OW'(DEPTH));
  assign wr_ready         = ~full_s;
  assign instruction_word = instr_q;
  assign issue_valid      = valid_q;
  assign occupancy        = occ_q;
  assign issued_count     = cnt_q;

  // Push readiness comes from registered occupancy only, so a same-cycle pop never frees room.
  always_comb begin
    push_s   = wr_en && !full_s && !flush;
    pop_s    = !flush && !stall && (occ_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      occ_d    = '0;
      instr_d  = NOP_WORD;
      valid_d  = 1'b0;
    end else if (stall) begin
      if (push_s) begin
        occ_d = occ_q + OW'(1);
      end else begin
        occ_d = occ_q;
      end
    end else if (pop_s) begin
      instr_d  = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d    = cnt_q + CNT_W'(1);
      if (push_s) begin
        occ_d = occ_q;
      end else begin
        occ_d = occ_q - OW'(1);
      end
    end else begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      if (push_s) begin
        occ_d = occ_q + OW'(1);
      end else begin
        occ_d = occ_q;
      end
    end
  end

  // Control and issue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= wr_instr;
    end
  end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Parametrised instruction buffer that sits between an instruction source and the RISC-V DataPath `instruction_word` input. It replaces hand-timed instruction sequencing with a FIFO that issues one instruction per cycle.
- Supports stall: issue is held. Supports flush: the queue is dropped and a bubble is inserted.
- When the queue is empty, it inserts NOP bubbles and keeps a count of issued instructions.

Parameters:
- XLEN, 32, instruction word width in bits.
- DEPTH, 8, number of queue entries; power of 2, minimum 2.
- NOP_WORD, 32'h00000013, bubble word (`addi x0,x0,0`) driven when nothing issues; XLEN bits.
- CNT_W, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  push request from the instruction source.
- wr_instr  in  XLEN  instruction word to push.
- wr_ready  out  1  queue not full; a push is accepted only when wr_en && wr_ready.
- stall  in  1  DataPath not ready; hold the current issue.
- flush  in  1  discard all queued words and the current issue.
- instruction_word  out  XLEN  registered instruction presented to DataPath.
- issue_valid  out  1  instruction_word holds a real popped instruction, not a bubble.
- occupancy  out  $clog2(DEPTH)+1  number of entries currently stored.
- issued_count  out  CNT_W  number of real instructions issued since reset.

Behaviour:
- Storage: circular buffer of DEPTH×XLEN entries.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - occupancy is a separate counter.
- Reset (rst=1 at an edge):
  - pointers=0, occupancy=0.
  - instruction_word=NOP_WORD, issue_valid=0, issued_count=0.
  - wr_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all contents and overrides every other input.
- wr_ready = (occupancy != DEPTH), combinational from registered state.
- Push:
  - Occurs when wr_en && wr_ready: write at wr_ptr, wr_ptr+1.
  - wr_en while full is ignored; no overwrite, no error flag.
  - A pop in the same cycle does not free space for that cycle's push.
- Pop and issue, when flush=0 and stall=0:
  - occupancy>0: instruction_word <= mem[rd_ptr], rd_ptr+1, issue_valid <= 1, issued_count+1 (wraps modulo 2^CNT_W).
  - occupancy==0: instruction_word <= NOP_WORD, issue_valid <= 0. Insert a bubble; no pop, count unchanged.
- Stall (stall=1, flush=0):
  - instruction_word, issue_valid and rd_ptr hold.
  - Pushes still accepted.
- Flush (flush=1):
  - Has priority over stall and pop.
  - rd_ptr <= wr_ptr, occupancy <= 0, instruction_word <= NOP_WORD, issue_valid <= 0.
  - A push in the same cycle is dropped, whether or not wr_ready=1.
- occupancy update: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- No bypass path:
  - A word accepted at edge E can issue at edge E+1 at the earliest.
  - It is visible on instruction_word after edge E+1.
- Ordering: strict FIFO; words issue in accept order with no loss or duplication.
- Never pop when empty. Never write when full.

Test Plan:
- Reset behaviour: rst high for 10 cycles, then low with no pushes → instruction_word=32'h00000013, issue_valid=0, occupancy=0, wr_ready=1 on every cycle.
- Single-push latency: push 32'h00100093 at edge E (stall=0) → after E+1, instruction_word=32'h00100093 and issue_valid=1. After E+2, instruction_word=NOP and issued_count=1.
- Fill and overflow: stall=1, push 9 distinct words (1..9) on consecutive cycles.
  - Expect occupancy=8, wr_ready=0, and word 9 dropped.
  - Then release stall: expect words 1..8 issued in order on 8 consecutive cycles, then NOP, issued_count=8.
- Stall hold: with 3 words queued, issue word A, then stall=1 for 4 cycles → instruction_word stays A, issue_valid=1, occupancy=2. After release, B then C issue.
- Flush: 5 words queued, assert flush with a simultaneous wr_en → next cycle occupancy=0, issue_valid=0, instruction_word=NOP. The pushed word never issues.
- Pointer wrap and counter: stream 20 words at one push per cycle, stall=0 → all 20 issue in order, with no bubbles after the first issue, and issued_count=20. With CNT_W=4, the same test gives issued_count=4 (wrap).
